// File: rtl/rgb_mode_ctrl.sv
// RGB LED mode controller: four edge-detected buttons drive an OFF/RUN FSM,
// a colour index and a brightness level that set a period-latched 8-bit PWM.
`timescale 1ns/1ps

module rgb_mode_ctrl #(
  parameter logic [2:0] LEVEL_RESET = 3'd4
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       btn_off,
  input  logic       btn_color,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic [2:0] color_sel,
  output logic [2:0] level,
  output logic       running
);

  localparam logic [0:0] ST_OFF = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;

  localparam logic [2:0] COLOR_LAST = 3'd6;
  localparam logic [2:0] LEVEL_MAX  = 3'd7;

  logic [0:0] state_q, state_d;
  logic [2:0] color_q, color_d;
  logic [2:0] level_q, level_d;
  logic [7:0] pwm_cnt_q;
  logic [7:0] duty_q, duty_d;
  logic [2:0] led_q, led_d;
  logic [3:0] btn_prev_q;

  logic [3:0] btn_now;
  logic [3:0] btn_event;
  logic       win_off, win_color, win_up, win_down;
  logic [2:0] color_mask;
  logic [7:0] duty_target;

  // Bit order everywhere: {off, color, up, down}, highest priority first.
  assign btn_now   = {btn_off, btn_color, btn_up, btn_down};
  assign btn_event = btn_now & ~btn_prev_q;

  assign win_off   = btn_event[3];
  assign win_color = btn_event[2] & ~btn_event[3];
  assign win_up    = btn_event[1] & ~(|btn_event[3:2]);
  assign win_down  = btn_event[0] & ~(|btn_event[3:1]);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    color_d = color_q;
    level_d = level_q;
    case (state_q)
      ST_OFF: begin
        if (win_color || win_up) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (win_off) begin
          state_d = ST_OFF;
        end else if (win_color) begin
          color_d = (color_q == COLOR_LAST) ? 3'd0 : color_q + 3'd1;
        end else if (win_up) begin
          level_d = (level_q == LEVEL_MAX) ? LEVEL_MAX : level_q + 3'd1;
        end else if (win_down) begin
          level_d = (level_q == 3'd0) ? 3'd0 : level_q - 3'd1;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_comb begin
    color_mask = 3'b000;
    case (color_q)
      3'd0: color_mask = 3'b100;
      3'd1: color_mask = 3'b010;
      3'd2: color_mask = 3'b001;
      3'd3: color_mask = 3'b110;
      3'd4: color_mask = 3'b011;
      3'd5: color_mask = 3'b101;
      3'd6: color_mask = 3'b111;
      default: color_mask = 3'b000;
    endcase
  end

  // Duty is latched only at the period wrap so a level change never
  // distorts the period already in progress.
  assign duty_target = (state_q == ST_RUN) ? {level_q, 5'b0} : 8'd0;
  assign duty_d      = (pwm_cnt_q == 8'hFF) ? duty_target : duty_q;
  assign led_d       = (pwm_cnt_q < duty_q) ? color_mask : 3'b000;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_OFF;
      color_q    <= 3'd0;
      level_q    <= LEVEL_RESET;
      pwm_cnt_q  <= 8'd0;
      duty_q     <= 8'd0;
      led_q      <= 3'b000;
      btn_prev_q <= 4'b0000;
    end else begin
      state_q    <= state_d;
      color_q    <= color_d;
      level_q    <= level_d;
      pwm_cnt_q  <= pwm_cnt_q + 8'd1;
      duty_q     <= duty_d;
      led_q      <= led_d;
      btn_prev_q <= btn_now;
    end
  end

  assign led_r     = led_q[2];
  assign led_g     = led_q[1];
  assign led_b     = led_q[0];
  assign color_sel = color_q;
  assign level     = level_q;
  assign running   = (state_q == ST_RUN);

endmodule
